// File: rtl/stack_op_sequencer_if.sv
// Request/response/redirect bundle between an upstream requester and the stack op sequencer.
// The master modport is the requester; the slave modport is the sequencer.
interface stack_op_sequencer_if #(
   parameter int WL = 32
);
   logic          req_valid;
   logic [1:0]    req_op;
   logic [WL-1:0] req_data;
   logic          req_ready;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [WL-1:0] rsp_data;
   logic          rsp_fault;
   logic          redirect_valid;
   logic [WL-1:0] redirect_pc;

   modport master (
      output req_valid, req_op, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_fault, redirect_valid, redirect_pc
   );

   modport slave (
      input  req_valid, req_op, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_fault, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/stack_op_sequencer.sv
// Front-end for the N x WL hardware stack: pre-checks full/empty, issues one strobe per request.
// Define STACK_SEQ_PEEK_EN to enable op 11 as PEEK (pop, then push the word back).
module stack_op_sequencer #(
   parameter int WL = 32,
   parameter int N  = 32
) (
   input  logic                     CLK,
   input  logic                     RESET,
   stack_op_sequencer_if.slave      bus,
   output logic                     stk_push,
   output logic                     stk_pop,
   output logic [WL-1:0]            stk_dio,
   input  logic                     stk_full,
   input  logic                     stk_empty,
   input  logic                     stk_error,
   input  logic [WL-1:0]            stk_data,
   output logic [$clog2(N+1)-1:0]   occ
);
   localparam int OW = $clog2(N+1);
   localparam logic [OW-1:0] OCC_MAX = OW'(N);

   localparam logic [1:0] OP_PUSH = 2'b00;
   localparam logic [1:0] OP_POP  = 2'b01;
   localparam logic [1:0] OP_RET  = 2'b10;
   localparam logic [1:0] OP_PEEK = 2'b11;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ISSUE   = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
`ifdef STACK_SEQ_PEEK_EN
   localparam logic [2:0] S_RESTORE = 3'd3;
`endif
   localparam logic [2:0] S_RESP    = 3'd4;

   logic [2:0]    state, state_d;
   logic [1:0]    op_q;
   logic [WL-1:0] data_q, word_q, pc_q;
   logic          fault_q, ready_q, redir_q;
   logic          accept, refuse;

   assign accept = bus.req_valid & ready_q;

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      refuse = 1'b0;
      case (bus.req_op)
         OP_PUSH: refuse = stk_full;
         OP_POP,
         OP_RET:  refuse = stk_empty;
`ifdef STACK_SEQ_PEEK_EN
         OP_PEEK: refuse = stk_empty;
`else
         OP_PEEK: refuse = 1'b1;
`endif
         default: refuse = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (accept) state_d = refuse ? S_RESP : S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
`ifdef STACK_SEQ_PEEK_EN
         S_WAIT:    state_d = (op_q == OP_PEEK && !stk_error) ? S_RESTORE : S_RESP;
         S_RESTORE: state_d = S_RESP;
`else
         S_WAIT:  state_d = S_RESP;
`endif
         S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state   <= S_IDLE;
         op_q    <= OP_PUSH;
         data_q  <= '0;
         word_q  <= '0;
         pc_q    <= '0;
         fault_q <= 1'b0;
         ready_q <= 1'b0;
         redir_q <= 1'b0;
         occ     <= '0;
      end else begin
         state   <= state_d;
         ready_q <= (state_d == S_IDLE);
         redir_q <= 1'b0;
         case (state)
            S_IDLE: if (accept) begin
               op_q    <= bus.req_op;
               data_q  <= bus.req_data;
               fault_q <= refuse;
               word_q  <= '0;
            end
            S_WAIT: begin
               fault_q <= stk_error;
               word_q  <= (op_q == OP_PUSH) ? data_q : stk_data;
               if (!stk_error) begin
                  case (op_q)
                     OP_PUSH: if (occ != OCC_MAX) occ <= occ + 1'b1;
                     OP_POP:  if (occ != '0) occ <= occ - 1'b1;
                     OP_RET: begin
                        if (occ != '0) occ <= occ - 1'b1;
                        redir_q <= 1'b1;
                        pc_q    <= stk_data;
                     end
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   // Strobes decode straight from state so an async reset drops them at once.
`ifdef STACK_SEQ_PEEK_EN
   assign stk_push = (state == S_ISSUE && op_q == OP_PUSH) || (state == S_RESTORE);
   assign stk_dio  = (state == S_RESTORE) ? word_q :
                     (state == S_ISSUE && op_q == OP_PUSH) ? data_q : '0;
`else
   assign stk_push = (state == S_ISSUE && op_q == OP_PUSH);
   assign stk_dio  = stk_push ? data_q : '0;
`endif
   assign stk_pop  = (state == S_ISSUE && op_q != OP_PUSH);

   assign bus.req_ready      = ready_q;
   assign bus.rsp_valid      = (state == S_RESP);
   assign bus.rsp_data       = word_q;
   assign bus.rsp_fault      = fault_q;
   assign bus.redirect_valid = redir_q;
   assign bus.redirect_pc    = pc_q;
endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed, table-driven bench for stack_op_sequencer with a behavioural 32-deep stack.
// Honours STACK_SEQ_PEEK_EN for the expected PEEK outcome.
module tb_stack_op_sequencer;
   localparam int WL = 32;
   localparam int N  = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stack_op_sequencer_if #(.WL(WL)) bus ();
   logic          stk_push, stk_pop, stk_full, stk_empty;
   logic          stk_error = 1'b0;
   logic [WL-1:0] stk_dio;
   logic [WL-1:0] stk_data = '0;
   logic [5:0]    occ;

   stack_op_sequencer #(.WL(WL), .N(N)) dut (
      .CLK(clk), .RESET(rst_n), .bus(bus),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_dio(stk_dio),
      .stk_full(stk_full), .stk_empty(stk_empty), .stk_error(stk_error),
      .stk_data(stk_data), .occ(occ)
   );

   // Behavioural stack the sequencer drives
   logic [WL-1:0] mem [N];
   int sp = 0;
   assign stk_full  = (sp == N);
   assign stk_empty = (sp == 0);
   always @(posedge clk) begin
      if (stk_push) begin
         if (sp == N) stk_error <= 1'b1;
         else begin mem[sp] <= stk_dio; sp <= sp + 1; end
      end else if (stk_pop) begin
         if (sp == 0) stk_error <= 1'b1;
         else begin stk_data <= mem[sp-1]; sp <= sp - 1; end
      end
   end

   int n_push, n_pop, n_redir, n_both;
   always @(posedge clk) begin
      if (stk_push) n_push++;
      if (stk_pop) n_pop++;
      if (bus.redirect_valid) n_redir++;
      if (stk_push && stk_pop) n_both++;
   end

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] data;
      int          hold;
      logic        exp_fault;
      logic [31:0] exp_data;
      int          exp_occ;
      int          exp_lat;
      int          exp_push;
      int          exp_pop;
      int          exp_redir;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] op, input logic [31:0] data, input int hold,
                               input logic f, input logic [31:0] d, input int o, input int l,
                               input int pu, input int po, input int rd);
      vec_t v;
      v.op = op; v.data = data; v.hold = hold; v.exp_fault = f; v.exp_data = d;
      v.exp_occ = o; v.exp_lat = l; v.exp_push = pu; v.exp_pop = po; v.exp_redir = rd;
      return v;
   endfunction

   // Latency counts clock edges from the accepting edge up to the first rsp_valid cycle.
   task automatic run_req(input vec_t v, input string name);
      int lat, waitc;
      logic [31:0] got_data, got_pc;
      logic got_fault, got_rv, stable;
      @(negedge clk);
      n_push = 0; n_pop = 0; n_redir = 0;
      bus.req_op = v.op; bus.req_data = v.data; bus.req_valid = 1'b1;
      waitc = 0;
      while (!bus.req_ready && waitc < 20) begin @(negedge clk); waitc++; end
      check({name, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      while (!bus.rsp_valid && lat < 10) begin @(posedge clk); lat++; @(negedge clk); end
      check({name, "_lat"}, lat, v.exp_lat);
      got_data = bus.rsp_data; got_fault = bus.rsp_fault;
      got_rv = bus.redirect_valid; got_pc = bus.redirect_pc;
      check({name, "_busy"}, {31'd0, bus.req_ready}, 32'd0);
      stable = 1'b1;
      repeat (v.hold) begin
         @(negedge clk);
         if (!bus.rsp_valid || bus.rsp_data !== got_data || bus.rsp_fault !== got_fault
             || bus.req_ready) stable = 1'b0;
      end
      if (v.hold > 0) check({name, "_stable"}, {31'd0, stable}, 32'd1);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check({name, "_fault"}, {31'd0, got_fault}, {31'd0, v.exp_fault});
      check({name, "_data"}, got_data, v.exp_data);
      check({name, "_occ"}, {26'd0, occ}, v.exp_occ);
      check({name, "_push"}, n_push, v.exp_push);
      check({name, "_pop"}, n_pop, v.exp_pop);
      check({name, "_redir"}, n_redir, v.exp_redir);
      if (v.exp_redir != 0) begin
         check({name, "_rv_first"}, {31'd0, got_rv}, 32'd1);
         check({name, "_pc"}, got_pc, v.exp_data);
      end
   endtask

   vec_t vecs [11];

   initial begin
      bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_data = '0; bus.rsp_ready = 1'b0;

      vecs[0]  = mk(2'b01, 32'h0,         0, 1'b1, 32'h0,         0, 1, 0, 0, 0);
      vecs[1]  = mk(2'b10, 32'h0,         0, 1'b1, 32'h0,         0, 1, 0, 0, 0);
      vecs[2]  = mk(2'b00, 32'hA5A5_0001, 0, 1'b0, 32'hA5A5_0001, 1, 3, 1, 0, 0);
      vecs[3]  = mk(2'b00, 32'h0000_0002, 0, 1'b0, 32'h0000_0002, 2, 3, 1, 0, 0);
      vecs[4]  = mk(2'b01, 32'h0,         0, 1'b0, 32'h0000_0002, 1, 3, 0, 1, 0);
      vecs[5]  = mk(2'b01, 32'h0,         0, 1'b0, 32'hA5A5_0001, 0, 3, 0, 1, 0);
      vecs[6]  = mk(2'b00, 32'h0000_1234, 0, 1'b0, 32'h0000_1234, 1, 3, 1, 0, 0);
`ifdef STACK_SEQ_PEEK_EN
      vecs[7]  = mk(2'b11, 32'h0,         0, 1'b0, 32'h0000_1234, 1, 4, 1, 1, 0);
`else
      vecs[7]  = mk(2'b11, 32'h0,         0, 1'b1, 32'h0,         1, 1, 0, 0, 0);
`endif
      vecs[8]  = mk(2'b01, 32'h0,         5, 1'b0, 32'h0000_1234, 0, 3, 0, 1, 0);
      vecs[9]  = mk(2'b00, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF, 1, 3, 1, 0, 0);
      vecs[10] = mk(2'b10, 32'h0,         2, 1'b0, 32'hDEAD_BEEF, 0, 3, 0, 1, 1);

      // Reset state
      #12;
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_fault", {31'd0, bus.rsp_fault}, 32'd0);
      check("rst_rsp_data", bus.rsp_data, 32'd0);
      check("rst_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
      check("rst_dio", stk_dio, 32'd0);
      check("rst_redirect", {31'd0, bus.redirect_valid}, 32'd0);
      check("rst_pc", bus.redirect_pc, 32'd0);
      check("rst_occ", {26'd0, occ}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

      for (int i = 0; i < 11; i++) run_req(vecs[i], $sformatf("vec%0d", i));

      // Fill to depth, overflow refused, then RET returns the last word
      for (int i = 0; i < N; i++)
         run_req(mk(2'b00, 32'h100 + i, 0, 1'b0, 32'h100 + i, i + 1, 3, 1, 0, 0),
                 $sformatf("fill%0d", i));
      run_req(mk(2'b00, 32'h999, 0, 1'b1, 32'h0, N, 1, 0, 0, 0), "overflow");
      run_req(mk(2'b10, 32'h0, 1, 1'b0, 32'h11F, N - 1, 3, 0, 1, 1), "ret_full");

      check("push_pop_exclusive", n_both, 0);

      // Reset in the middle of a POP: strobe drops immediately, no response follows
      @(negedge clk);
      bus.req_op = 2'b01; bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("midop_pop_issued", {31'd0, stk_pop}, 32'd1);
      rst_n = 1'b0; #1;
      check("midop_pop_dropped", {31'd0, stk_pop}, 32'd0);
      check("midop_occ", {26'd0, occ}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("midop_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      check("midop_ready", {31'd0, bus.req_ready}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
